// File: rtl/receiver_pkg.sv
// Shared UART receive definitions: clock/FIFO defaults, frame-format codes,
// receiver FSM states and a 2-of-3 vote helper.
package receiver_pkg;

  localparam int SYSTEM_CLOCK_FREQ = 50_000_000;
  localparam int RX_FIFO_DEPTH     = 64;

  localparam logic [1:0] DW_5BIT = 2'd0;
  localparam logic [1:0] DW_6BIT = 2'd1;
  localparam logic [1:0] DW_7BIT = 2'd2;
  localparam logic [1:0] DW_8BIT = 2'd3;

  localparam logic [1:0] SB_1BIT = 2'd0;
  localparam logic [1:0] SB_2BIT = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } receiver_fsm_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/receiver_if.sv
// Receiver-side bus: baud tick, serial line, frame format, FIFO read port and status pulses.
interface receiver_if;
  logic       ov_baud_rt_i;
  logic       rx_i;
  logic       rx_fifo_read_i;
  logic [1:0] data_width_i;
  logic [1:0] stop_bits_number_i;
  logic [1:0] parity_mode_i;
  logic [7:0] rx_data_o;
  logic       rx_done_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       cfg_req_slv_o;
  logic       rx_fifo_empty_o;
  logic       rx_fifo_full_o;

  modport slave (
    input  ov_baud_rt_i, rx_i, rx_fifo_read_i, data_width_i, stop_bits_number_i, parity_mode_i,
    output rx_data_o, rx_done_o, parity_err_o, frame_err_o, overrun_o, cfg_req_slv_o,
           rx_fifo_empty_o, rx_fifo_full_o
  );

  modport master (
    output ov_baud_rt_i, rx_i, rx_fifo_read_i, data_width_i, stop_bits_number_i, parity_mode_i,
    input  rx_data_o, rx_done_o, parity_err_o, frame_err_o, overrun_o, cfg_req_slv_o,
           rx_fifo_empty_o, rx_fifo_full_o
  );
endinterface

// File: rtl/receiver_fifo.sv
// First-word-fall-through synchronous FIFO holding received characters.
// The head is presented combinationally; an empty FIFO presents zero.
module receiver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // validity, and an empty FIFO forces the head to zero.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/receiver.sv
// UART receiver: 16x oversampled framing, parity/stop checks, FWFT RX FIFO and
// 10 ms line-low configuration-request detect. Define RX_MAJORITY_VOTE_EN for 2-of-3 bit voting.
module receiver #(
  parameter int RX_FIFO_DEPTH = receiver_pkg::RX_FIFO_DEPTH,
  parameter int COUNT_10MS    = receiver_pkg::SYSTEM_CLOCK_FREQ / 100
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  receiver_if.slave  bus
);
  import receiver_pkg::*;

  localparam int CW = $clog2(COUNT_10MS + 1);

  receiver_fsm_e r_state, w_state_nxt;

  logic       r_sync1, r_rx_s, r_rx_prev;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic [7:0] r_data;
  logic [1:0] r_dw, r_sb, r_pm;
  logic       r_par_flag, r_frm_flag;
  logic       r_done, r_par_err, r_frm_err, r_cfg_req;
  logic [CW-1:0] r_low_cnt;

  logic w_fall, w_bit, w_tick, w_dec7, w_dec15, w_full;
  logic w_cnt_clr, w_start, w_shift, w_par_chk, w_stop_smp, w_frame_end;

  assign w_tick  = bus.ov_baud_rt_i;
  assign w_fall  = r_rx_prev & ~r_rx_s;
  assign w_dec7  = w_tick && (r_tick_cnt == 4'd7);
  assign w_dec15 = w_tick && (r_tick_cnt == 4'd15);

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= bus.rx_i;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    r_hist <= 2'b11;
    else if (w_tick) r_hist <= {r_hist[0], r_rx_s};
  end
  assign w_bit = majority3(r_hist[1], r_hist[0], r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_smp  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: if (w_fall) begin
        w_cnt_clr   = 1'b1;
        w_start     = 1'b1;
        w_state_nxt = START;
      end
      START: if (w_dec7) begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = w_bit ? IDLE : DATA;
      end
      DATA: if (w_dec15) begin
        w_shift = 1'b1;
        if (r_bit_cnt == {1'b0, r_dw} + 3'd4) w_state_nxt = r_pm[1] ? STOP : PARITY;
      end
      PARITY: if (w_dec15) begin
        w_par_chk   = 1'b1;
        w_state_nxt = STOP;
      end
      STOP: if (w_dec15) begin
        w_stop_smp = 1'b1;
        if (!(r_sb == SB_2BIT && !r_stop_cnt)) begin
          w_frame_end = 1'b1;
          w_state_nxt = r_rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (r_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tick counter: the edge-detect clear wins over a coincident tick.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       r_tick_cnt <= '0;
    else if (w_cnt_clr) r_tick_cnt <= '0;
    else if (w_tick)    r_tick_cnt <= r_tick_cnt + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_dw       <= DW_8BIT;
      r_sb       <= SB_1BIT;
      r_pm       <= 2'b10;
      r_par_flag <= 1'b0;
      r_frm_flag <= 1'b0;
      r_done     <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_done    <= w_frame_end;
      r_par_err <= w_frame_end & r_par_flag;
      r_frm_err <= w_frame_end & (r_frm_flag | ~w_bit);
      if (w_start) begin
        r_data     <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_par_flag <= 1'b0;
        r_frm_flag <= 1'b0;
        r_dw       <= bus.data_width_i;
        r_sb       <= bus.stop_bits_number_i;
        r_pm       <= bus.parity_mode_i;
      end
      if (w_shift) begin
        r_data[r_bit_cnt] <= w_bit;
        r_bit_cnt         <= r_bit_cnt + 3'd1;
      end
      if (w_par_chk) r_par_flag <= w_bit ^ (^r_data) ^ r_pm[0];
      if (w_stop_smp) begin
        r_stop_cnt <= 1'b1;
        if (!w_bit) r_frm_flag <= 1'b1;
      end
    end
  end

  // Configuration request: consecutive low clocks, one pulse, then saturate until the line rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_low_cnt <= '0;
      r_cfg_req <= 1'b0;
    end else begin
      r_cfg_req <= ~r_rx_s && (r_low_cnt == CW'(COUNT_10MS - 1));
      if (r_rx_s)                            r_low_cnt <= '0;
      else if (r_low_cnt != CW'(COUNT_10MS)) r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  receiver_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_push  (r_done),
    .i_data  (r_data),
    .i_pop   (bus.rx_fifo_read_i),
    .o_data  (bus.rx_data_o),
    .o_empty (bus.rx_fifo_empty_o),
    .o_full  (w_full)
  );

  assign bus.rx_fifo_full_o = w_full;
  assign bus.rx_done_o      = r_done;
  assign bus.parity_err_o   = r_par_err;
  assign bus.frame_err_o    = r_frm_err;
  assign bus.overrun_o      = r_done & w_full & ~bus.rx_fifo_read_i;
  assign bus.cfg_req_slv_o  = r_cfg_req;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: serial frames driven per baud tick, checked
// against a queue model of the FIFO and frame-level expectations.
module tb_receiver;
  import receiver_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT10 = 1000;
  localparam int P     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tick_div = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cfg_cnt  = 0;
  int stray    = 0;
  logic last_par, last_frm, last_ovr;
  logic [7:0] q[$];

  receiver_if bus ();

  receiver #(.RX_FIFO_DEPTH(DEPTH), .COUNT_10MS(CNT10)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_div = (tick_div == P - 1) ? 0 : tick_div + 1;
    bus.ov_baud_rt_i = (tick_div == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_done_o) begin
        done_cnt++;
        last_par = bus.parity_err_o;
        last_frm = bus.frame_err_o;
        last_ovr = bus.overrun_o;
      end else if (bus.parity_err_o || bus.frame_err_o || bus.overrun_o) begin
        stray++;
      end
      if (bus.cfg_req_slv_o) cfg_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!bus.ov_baud_rt_i);
    end
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge clk);
    bus.rx_i = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] dw,
                            input logic [1:0] sb, input logic [1:0] pm, input bit bad_par,
                            input bit bad_stop, input int extra_low, input int glitch_bit);
    int nbits, nstop, d0;
    logic [7:0] masked;
    logic p;
    bit exp_ovr;
    nbits  = int'(dw) + 5;
    nstop  = (sb == SB_2BIT) ? 2 : 1;
    masked = d & 8'((1 << nbits) - 1);
    bus.data_width_i       = dw;
    bus.stop_bits_number_i = sb;
    bus.parity_mode_i      = pm;
    d0 = done_cnt;
    drive(1'b0, 16);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        drive(d[i], 7);
        drive(~d[i], 1);
        drive(d[i], 8);
      end else begin
        drive(d[i], 16);
      end
    end
    p = (^masked) ^ pm[0];
    if (!pm[1]) drive(bad_par ? ~p : p, 16);
    for (int s = 0; s < nstop; s++) drive((bad_stop && s == nstop - 1) ? 1'b0 : 1'b1, 16);
    if (extra_low > 0) drive(1'b0, extra_low);
    drive(1'b1, 4);
    exp_ovr = (q.size() == DEPTH);
    if (!exp_ovr) q.push_back(masked);
    check({tag, ".done"}, done_cnt - d0, 1);
    check({tag, ".parity_err"}, last_par, bad_par && !pm[1]);
    check({tag, ".frame_err"}, last_frm, bad_stop);
    check({tag, ".overrun"}, last_ovr, exp_ovr);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, ".empty"}, bus.rx_fifo_empty_o, 0);
    check({tag, ".data"}, bus.rx_data_o, q[0]);
    bus.rx_fifo_read_i = 1'b1;
    @(negedge clk);
    bus.rx_fifo_read_i = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_check(tag);
    @(negedge clk);
    check({tag, ".empty_after"}, bus.rx_fifo_empty_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".empty"}, bus.rx_fifo_empty_o, 1);
    check({tag, ".full"}, bus.rx_fifo_full_o, 0);
    check({tag, ".data"}, bus.rx_data_o, 0);
    check({tag, ".done"}, bus.rx_done_o, 0);
    check({tag, ".errs"}, {bus.parity_err_o, bus.frame_err_o, bus.overrun_o}, 0);
    check({tag, ".cfg"}, bus.cfg_req_slv_o, 0);
  endtask

  initial begin
    int d0, c0;
    logic [7:0] first;
    bus.rx_i = 1'b1;
    bus.rx_fifo_read_i = 1'b0;
    bus.data_width_i = DW_8BIT;
    bus.stop_bits_number_i = SB_1BIT;
    bus.parity_mode_i = 2'b10;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 8N1 clean frame
    send_frame("8n1_a5", 8'hA5, DW_8BIT, SB_1BIT, 2'b10, 0, 0, 0, -1);
    check("8n1_a5.empty_drop", bus.rx_fifo_empty_o, 0);
    drain("8n1_a5");

    // 7E2 with corrupted parity
    send_frame("7e2_35", 8'h35, DW_7BIT, SB_2BIT, 2'b00, 1, 0, 0, -1);
    drain("7e2_35");

    // 5N1 with low stop bit and line held low afterwards
    send_frame("5n1_1f", 8'h1F, DW_5BIT, SB_1BIT, 2'b10, 0, 1, 16, -1);
    d0 = done_cnt;
    drive(1'b1, 32);
    check("wait_idle.no_second", done_cnt - d0, 0);
    drain("5n1_1f");

    // Start-bit glitch of 4 ticks
    d0 = done_cnt;
    drive(1'b0, 4);
    drive(1'b1, 40);
    check("glitch.no_done", done_cnt - d0, 0);
    check("glitch.empty", bus.rx_fifo_empty_o, 1);

`ifdef RX_MAJORITY_VOTE_EN
    send_frame("vote_00", 8'h00, DW_8BIT, SB_1BIT, 2'b10, 0, 0, 0, 3);
    drain("vote_00");
`endif

    // Randomized formats and errors, random interleaved reads
    for (int n = 0; n < 12; n++) begin
      send_frame("rand", 8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 0, -1);
      if ($urandom_range(0, 1) == 1) pop_check("rand_pop");
    end
    drain("rand");

    // Read while empty is ignored
    @(negedge clk);
    bus.rx_fifo_read_i = 1'b1;
    @(negedge clk);
    bus.rx_fifo_read_i = 1'b0;
    check("empty_read.empty", bus.rx_fifo_empty_o, 1);
    check("empty_read.data", bus.rx_data_o, 0);

    // Fill, then overrun
    for (int n = 0; n < DEPTH; n++)
      send_frame("fill", 8'($urandom), DW_8BIT, SB_1BIT, 2'b10, 0, 0, 0, -1);
    check("fill.full", bus.rx_fifo_full_o, 1);
    first = q[0];
    send_frame("ovr_77", 8'h77, DW_8BIT, SB_1BIT, 2'b10, 0, 0, 0, -1);
    check("ovr.still_full", bus.rx_fifo_full_o, 1);
    check("ovr.head_first", bus.rx_data_o, first);
    drain("ovr");

    // Configuration request: one pulse per sustained low, re-armed by a high line
    c0 = cfg_cnt;
    @(negedge clk);
    bus.rx_i = 1'b0;
    repeat (CNT10 + 100) @(negedge clk);
    check("cfg.one_pulse", cfg_cnt - c0, 1);
    drive(1'b1, 8);
    check("cfg.no_extra", cfg_cnt - c0, 1);
    @(negedge clk);
    bus.rx_i = 1'b0;
    repeat (CNT10 + 100) @(negedge clk);
    check("cfg.rearm", cfg_cnt - c0, 2);
    drive(1'b1, 8);

    // Reset mid-frame
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    d0 = done_cnt;
    wait_ticks(200);
    check("midreset.no_done", done_cnt - d0, 0);
    send_frame("post_reset", 8'h3C, DW_8BIT, SB_1BIT, 2'b11, 0, 0, 0, -1);
    drain("post_reset");

    check("stray_error_pulses", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
